// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour BCD time-of-day counter with a 1 Hz prescaler
// and a validated synchronous preset port.
module bcd_time_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic [3:0] ld_h_t,
    input  logic [3:0] ld_h_u,
    input  logic [3:0] ld_m_t,
    input  logic [3:0] ld_m_u,
    input  logic [3:0] ld_s_t,
    input  logic [3:0] ld_s_u,
    output logic [3:0] h_t,
    output logic [3:0] h_u,
    output logic [3:0] m_t,
    output logic [3:0] m_u,
    output logic [3:0] s_t,
    output logic [3:0] s_u,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       load_err
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_pre;
    logic          w_wrap;
    logic          w_valid;
    logic          w_do_load;
    logic          w_adv;
    logic          w_c_su, w_c_st, w_c_mu, w_c_mt, w_day;
    logic [3:0]    w_h_t, w_h_u, w_m_t, w_m_u, w_s_t, w_s_u;

    assign w_wrap    = run && (r_pre == PRE_TOP);
    assign w_valid   = (ld_h_t <= 4'd2) && (ld_h_u <= 4'd9) && !((ld_h_t == 4'd2) && (ld_h_u > 4'd3))
                    && (ld_m_t <= 4'd5) && (ld_m_u <= 4'd9)
                    && (ld_s_t <= 4'd5) && (ld_s_u <= 4'd9);
    assign w_do_load = load && w_valid;
    // a valid load discards a coincident advance
    assign w_adv     = w_wrap && !w_do_load;

    always_comb begin
        w_c_su = (s_u == 4'd9);
        w_c_st = w_c_su && (s_t == 4'd5);
        w_c_mu = w_c_st && (m_u == 4'd9);
        w_c_mt = w_c_mu && (m_t == 4'd5);
        w_day  = w_c_mt && (h_t == 4'd2) && (h_u == 4'd3);
        w_s_u  = w_c_su ? 4'd0 : s_u + 4'd1;
        w_s_t  = w_c_su ? (w_c_st ? 4'd0 : s_t + 4'd1) : s_t;
        w_m_u  = w_c_st ? (w_c_mu ? 4'd0 : m_u + 4'd1) : m_u;
        w_m_t  = w_c_mu ? (w_c_mt ? 4'd0 : m_t + 4'd1) : m_t;
        w_h_u  = w_c_mt ? ((w_day || h_u == 4'd9) ? 4'd0 : h_u + 4'd1) : h_u;
        w_h_t  = w_day ? 4'd0 : (w_c_mt && h_u == 4'd9) ? h_t + 4'd1 : h_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            h_t      <= '0;
            h_u      <= '0;
            m_t      <= '0;
            m_u      <= '0;
            s_t      <= '0;
            s_u      <= '0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= w_adv;
            day_tick <= w_adv && w_day;
            load_err <= load && !w_valid;
            if (w_do_load) begin
                r_pre <= '0;
                h_t   <= ld_h_t;
                h_u   <= ld_h_u;
                m_t   <= ld_m_t;
                m_u   <= ld_m_u;
                s_t   <= ld_s_t;
                s_u   <= ld_s_u;
            end else begin
                if (run)
                    r_pre <= w_wrap ? '0 : r_pre + PW'(1);
                if (w_adv) begin
                    h_t <= w_h_t;
                    h_u <= w_h_u;
                    m_t <= w_m_t;
                    m_u <= w_m_u;
                    s_t <= w_s_t;
                    s_u <= w_s_u;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed self-checking bench for bcd_time_counter
// with CLK_HZ=4; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bcd_time_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_h_t = '0, ld_h_u = '0, ld_m_t = '0, ld_m_u = '0, ld_s_t = '0, ld_s_u = '0;
    logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
    logic       sec_tick, day_tick, load_err;
    int         checks = 0;
    int         failures = 0;

    bcd_time_counter #(.CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .run(run), .load(load),
        .ld_h_t(ld_h_t), .ld_h_u(ld_h_u), .ld_m_t(ld_m_t),
        .ld_m_u(ld_m_u), .ld_s_t(ld_s_t), .ld_s_u(ld_s_u),
        .h_t(h_t), .h_u(h_u), .m_t(m_t), .m_u(m_u), .s_t(s_t), .s_u(s_u),
        .sec_tick(sec_tick), .day_tick(day_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [23:0] t, input logic st, input logic dt, input logic le);
        chk({tag, " time"}, {h_t, h_u, m_t, m_u, s_t, s_u}, t);
        chk({tag, " sec_tick"}, {23'd0, sec_tick}, {23'd0, st});
        chk({tag, " day_tick"}, {23'd0, day_tick}, {23'd0, dt});
        chk({tag, " load_err"}, {23'd0, load_err}, {23'd0, le});
    endtask

    task automatic do_load(input logic [23:0] t);
        {ld_h_t, ld_h_u, ld_m_t, ld_m_u, ld_s_t, ld_s_u} = t;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    logic [23:0] bad [5] = '{24'h240000, 24'h126000, 24'h12000A, 24'h245959, 24'h300000};

    initial begin
        #2;
        chk_state("reset", 24'h000000, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        run = 1'b1;
        tick(3);
        chk_state("pre first tick", 24'h000000, 0, 0, 0);
        tick(1);
        chk_state("first tick", 24'h000001, 1, 0, 0);
        tick(3);
        chk_state("between ticks", 24'h000001, 0, 0, 0);
        tick(1);
        chk_state("second tick", 24'h000002, 1, 0, 0);

        do_load(24'h235958);
        chk_state("load 23:59:58", 24'h235958, 0, 0, 0);
        tick(4);
        chk_state("23:59:59", 24'h235959, 1, 0, 0);
        tick(4);
        chk_state("rollover", 24'h000000, 1, 1, 0);
        tick(1);
        chk_state("after rollover", 24'h000000, 0, 0, 0);

        do_load(24'h095959);
        tick(4);
        chk_state("carry 10:00:00", 24'h100000, 1, 0, 0);
        do_load(24'h195959);
        tick(4);
        chk_state("carry 20:00:00", 24'h200000, 1, 0, 0);

        foreach (bad[i]) begin
            do_load(24'h120000);
            do_load(bad[i]);
            chk_state($sformatf("invalid load %h", bad[i]), 24'h120000, 0, 0, 1);
            tick(1);
            chk_state($sformatf("after invalid %h", bad[i]), 24'h120000, 0, 0, 0);
        end

        do_load(24'h000000);
        tick(3);
        do_load(24'h123456);
        chk_state("valid load collision", 24'h123456, 0, 0, 0);
        tick(3);
        chk_state("after collision no tick", 24'h123456, 0, 0, 0);
        tick(1);
        chk_state("after collision tick", 24'h123457, 1, 0, 0);
        tick(3);
        do_load(24'h126000);
        chk_state("invalid load collision", 24'h123458, 1, 0, 1);

        tick(2);
        run = 1'b0;
        tick(10);
        chk_state("frozen", 24'h123458, 0, 0, 0);
        run = 1'b1;
        tick(1);
        chk_state("resume no tick", 24'h123458, 0, 0, 0);
        tick(1);
        chk_state("resume tick", 24'h123459, 1, 0, 0);

        {ld_h_t, ld_h_u, ld_m_t, ld_m_u, ld_s_t, ld_s_u} = 24'h010000;
        load = 1'b1;
        tick(6);
        load = 1'b0;
        chk_state("held load", 24'h010000, 0, 0, 0);
        tick(3);
        chk_state("after held load no tick", 24'h010000, 0, 0, 0);
        tick(1);
        chk_state("after held load tick", 24'h010001, 1, 0, 0);

        do_load(24'h050606);
        tick(4);
        chk_state("showing 05:06:07", 24'h050607, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async reset", 24'h000000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_load(24'h990000);
        chk_state("err before reset", 24'h000000, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_state("reset clears load_err", 24'h000000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(3);
        chk_state("post reset no tick", 24'h000000, 0, 0, 0);
        tick(1);
        chk_state("post reset tick", 24'h000001, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
